// File: rtl/zx8x_tape_player.sv
// ZX80/ZX81 cassette playback: streams a tape-buffer image out as the EAR pulse
// train the ROM loader expects (MSB first, 4 pulses per 0 bit, 9 per 1 bit).
module zx8x_tape_player #(
    parameter int unsigned CLK_DIV     = 52,
    parameter int unsigned PULSE_HI_US = 150,
    parameter int unsigned PULSE_LO_US = 150,
    parameter int unsigned GAP_US      = 1300,
    parameter int unsigned LEADER_US   = 1000000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic        prepend_name,
    input  logic [13:0] len,
    output logic [13:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    output logic        tape_out,
    output logic        busy,
    output logic        done
);

    localparam int unsigned PW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned MAX_A  = (PULSE_HI_US > PULSE_LO_US) ? PULSE_HI_US : PULSE_LO_US;
    localparam int unsigned MAX_B  = (GAP_US > LEADER_US) ? GAP_US : LEADER_US;
    localparam int unsigned MAX_US = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned DW     = $clog2(MAX_US + 1);

    localparam logic [PW-1:0] PRESC_LAST  = PW'(CLK_DIV - 1);
    localparam logic [DW-1:0] HI_LAST     = DW'(PULSE_HI_US - 1);
    localparam logic [DW-1:0] LO_LAST     = DW'(PULSE_LO_US - 1);
    localparam logic [DW-1:0] GAP_LAST    = DW'(GAP_US - 1);
    localparam logic [DW-1:0] LEADER_LAST = DW'(LEADER_US - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEADER,
        S_FETCH,
        S_WAITDATA,
        S_PULSE_H,
        S_PULSE_L,
        S_GAP,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [DW-1:0] dur_q, dur_d;
    logic [1:0]    wait_q, wait_d;
    logic [13:0]   index_q, index_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_q, bit_d;
    logic [3:0]    pcnt_q, pcnt_d;
    logic          name_q, name_d;
    logic [13:0]   mem_addr_q, mem_addr_d;
    logic          mem_rd_q, mem_rd_d;
    logic          tape_q, tape_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          tick;
    logic [DW-1:0] dur_last;
    logic          dur_end;

    assign tick = busy_q && (presc_q == PRESC_LAST);

    always_comb begin
        dur_last = '0;
        case (state_q)
            S_LEADER:  dur_last = LEADER_LAST;
            S_PULSE_H: dur_last = HI_LAST;
            S_PULSE_L: dur_last = LO_LAST;
            S_GAP:     dur_last = GAP_LAST;
            default:   dur_last = '0;
        endcase
    end

    assign dur_end = tick && (dur_q == dur_last);

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        dur_d      = dur_q;
        wait_d     = wait_q;
        index_d    = index_q;
        shift_d    = shift_q;
        bit_d      = bit_q;
        pcnt_d     = pcnt_q;
        name_d     = name_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = 1'b0;
        busy_d     = busy_q;
        done_d     = done_q;

        if (busy_q) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
        if (tick) begin
            dur_d = dur_q + 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LEADER;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    index_d = '0;
                    name_d  = prepend_name;
                    presc_d = '0;
                    dur_d   = '0;
                end
            end
            S_LEADER: begin
                if (dur_end) begin
                    state_d = S_FETCH;
                    dur_d   = '0;
                end
            end
            S_FETCH: begin
                if (name_q) begin
                    name_d  = 1'b0;
                    shift_d = 8'h80;
                    bit_d   = 3'd7;
                    pcnt_d  = 4'd9;
                    dur_d   = '0;
                    state_d = S_PULSE_H;
                end else if (index_q == len) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    mem_addr_d = index_q;
                    mem_rd_d   = 1'b1;
                    wait_d     = '0;
                    state_d    = S_WAITDATA;
                end
            end
            S_WAITDATA: begin
                // Strobe cycle plus one idle cycle; data is sampled on the third edge.
                if (wait_q == 2'd2) begin
                    shift_d = mem_data;
                    index_d = index_q + 14'd1;
                    bit_d   = 3'd7;
                    pcnt_d  = mem_data[7] ? 4'd9 : 4'd4;
                    dur_d   = '0;
                    state_d = S_PULSE_H;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            S_PULSE_H: begin
                if (dur_end) begin
                    dur_d   = '0;
                    state_d = S_PULSE_L;
                end
            end
            S_PULSE_L: begin
                if (dur_end) begin
                    dur_d   = '0;
                    pcnt_d  = pcnt_q - 4'd1;
                    state_d = (pcnt_q != 4'd1) ? S_PULSE_H : S_GAP;
                end
            end
            S_GAP: begin
                if (dur_end) begin
                    dur_d = '0;
                    if (bit_q != 3'd0) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        bit_d   = bit_q - 3'd1;
                        pcnt_d  = shift_q[6] ? 4'd9 : 4'd4;
                        state_d = S_PULSE_H;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (stop) begin
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            mem_rd_d = 1'b0;
            name_d   = 1'b0;
            presc_d  = '0;
            dur_d    = '0;
        end

        tape_d = (state_d == S_PULSE_H);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            dur_q      <= '0;
            wait_q     <= '0;
            index_q    <= '0;
            shift_q    <= '0;
            bit_q      <= '0;
            pcnt_q     <= '0;
            name_q     <= 1'b0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            tape_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            dur_q      <= dur_d;
            wait_q     <= wait_d;
            index_q    <= index_d;
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            pcnt_q     <= pcnt_d;
            name_q     <= name_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            tape_q     <= tape_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_rd   = mem_rd_q;
    assign tape_out = tape_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_zx8x_tape_player.sv
// Scoreboarded bench for zx8x_tape_player: a byte-level model queues expected
// read addresses and per-bit pulse counts; a monitor decodes the EAR waveform.
module tb_zx8x_tape_player;

    // Shortened pulse timings keep every scenario well inside the cycle budget.
    localparam int unsigned DIV  = 2;
    localparam int unsigned LEAD = 10;
    localparam int unsigned HI   = 3;
    localparam int unsigned LO   = 4;
    localparam int unsigned GAP  = 20;

    localparam int HI_C     = HI * DIV;
    localparam int LO_C     = LO * DIV;
    localparam int GAPLOW_C = LO_C + GAP * DIV;
    localparam int CLOSE_C  = LO_C + (GAP * DIV) / 2;
    localparam int LEAD_C   = LEAD * DIV;

    typedef struct {
        int pulses;
        bit first;
    } grp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic        prepend_name;
    logic [13:0] len;
    logic [13:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data = 8'h00;
    logic        tape_out;
    logic        busy;
    logic        done;

    logic [7:0]  mem [0:15];
    logic        rd_d1 = 1'b0;
    logic [13:0] a_d1 = '0;

    grp_t exp_grp[$];
    int   exp_addr[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    bit   prev_t, prev_done, in_grp, had_pulse, first_pend;
    int   hi_len, lo_len, pulses, since;

    always #5 clk = ~clk;

    zx8x_tape_player #(
        .CLK_DIV    (DIV),
        .PULSE_HI_US(HI),
        .PULSE_LO_US(LO),
        .GAP_US     (GAP),
        .LEADER_US  (LEAD)
    ) dut (
        .clk_sys     (clk),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .prepend_name(prepend_name),
        .len         (len),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .tape_out    (tape_out),
        .busy        (busy),
        .done        (done)
    );

    // Tape buffer: address registered with the strobe, data one cycle later, then held.
    always @(posedge clk) begin
        rd_d1 <= mem_rd;
        a_d1  <= mem_addr;
        if (rd_d1) mem_data <= mem[a_d1[3:0]];
    end

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        chk_rng(name, act, exp, exp);
    endtask

    task automatic fail(input string name, input int act);
        checks++;
        errors++;
        $display("FAIL %s: got %0d, expected nothing", name, act);
    endtask

    // Reference: each played byte (optional 0x80 name first) yields 8 MSB-first
    // bit groups of 9 pulses for a 1 and 4 for a 0; image bytes are read in order.
    task automatic model(input int n, input bit pre);
        logic [7:0] b;
        grp_t g;
        for (int i = 0; i < n; i++) exp_addr.push_back(i);
        for (int k = (pre ? -1 : 0); k < n; k++) begin
            b = (k < 0) ? 8'h80 : mem[k];
            for (int j = 7; j >= 0; j--) begin
                g.pulses = b[j] ? 9 : 4;
                g.first  = (j == 7);
                exp_grp.push_back(g);
            end
        end
    endtask

    always @(negedge clk) begin
        grp_t g;
        if (!mon_en) begin
            in_grp     = 1'b0;
            prev_t     = 1'b0;
            prev_done  = done;
            had_pulse  = 1'b0;
            first_pend = 1'b0;
            hi_len     = 0;
            lo_len     = 0;
            pulses     = 0;
        end else begin
            since++;
            if (start && !stop && !busy) begin
                since      = 0;
                first_pend = 1'b1;
                had_pulse  = 1'b0;
            end
            if (mem_rd) begin
                if (exp_addr.size() == 0) fail("mem_rd_unexpected", int'(mem_addr));
                else chk("mem_addr", int'(mem_addr), exp_addr.pop_front());
            end
            if (tape_out) begin
                if (!prev_t) begin
                    if (first_pend) begin
                        chk_rng("leader", since, LEAD_C + 1, LEAD_C + 6);
                        first_pend = 1'b0;
                    end
                    if (!in_grp) begin
                        if (exp_grp.size() == 0) fail("pulse_unexpected", since);
                        else if (!exp_grp[0].first && had_pulse) chk("bit_gap", lo_len, GAPLOW_C);
                        in_grp = 1'b1;
                        pulses = 1;
                    end else begin
                        chk("pulse_lo", lo_len, LO_C);
                        pulses++;
                    end
                    hi_len = 0;
                end
                hi_len++;
            end else begin
                if (prev_t) begin
                    chk_rng("pulse_hi", hi_len, HI_C - int'(DIV) + 1, HI_C);
                    lo_len    = 0;
                    had_pulse = 1'b1;
                end
                lo_len++;
                if (in_grp && lo_len == CLOSE_C) begin
                    if (exp_grp.size() == 0) fail("group_unexpected", pulses);
                    else begin
                        g = exp_grp.pop_front();
                        chk("bit_pulses", pulses, g.pulses);
                    end
                    in_grp = 1'b0;
                end
            end
            if (done && !prev_done && had_pulse) chk_rng("done_latency", lo_len, GAPLOW_C, GAPLOW_C + 5);
            prev_t    = tape_out;
            prev_done = done;
        end
    end

    task automatic kick(input int n, input bit pre);
        @(posedge clk);
        #1;
        len          = 14'(n);
        prepend_name = pre;
        model(n, pre);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (cnt < 30000) begin
            @(negedge clk);
            cnt++;
            if (done) break;
        end
        if (!done) fail("done_timeout", cnt);
        #1;
        chk("end_busy", int'(busy), 0);
        chk("end_done", int'(done), 1);
        chk("end_tape", int'(tape_out), 0);
        chk("groups_left", exp_grp.size(), 0);
        chk("reads_left", exp_addr.size(), 0);
    endtask

    task automatic run(input int n, input bit pre, output int cnt);
        kick(n, pre);
        wait_done(cnt);
    endtask

    task automatic flush();
        mon_en = 1'b0;
        exp_grp.delete();
        exp_addr.delete();
        repeat (2) @(negedge clk);
        #1;
        mon_en = 1'b1;
    endtask

    initial begin
        int cnt;
        int n;
        bit pre;
        reset_n      = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
        prepend_name = 1'b0;
        len          = '0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tape", int'(tape_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_mem_rd", int'(mem_rd), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Asynchronous reset while a pulse is high
        mem[0] = 8'h55;
        kick(1, 1'b0);
        cnt = 0;
        while (cnt < 500 && !tape_out) begin
            @(negedge clk);
            cnt++;
        end
        if (!tape_out) fail("pulse_timeout", cnt);
        #2;
        reset_n = 1'b0;
        #1;
        mon_en = 1'b0;
        chk("arst_tape", int'(tape_out), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        flush();

        mem[0] = 8'h00;
        run(1, 1'b0, cnt);
        mem[0] = 8'hFF;
        run(1, 1'b0, cnt);
        run(0, 1'b1, cnt);
        mem[0] = 8'hA5;
        mem[1] = 8'h3C;
        mem[2] = 8'h01;
        run(3, 1'b0, cnt);
        run(0, 1'b0, cnt);
        chk("empty_play_time", cnt, LEAD_C + 2);

        // Simultaneous start and stop from DONE: stop wins
        @(posedge clk);
        #1;
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        chk("ss_busy", int'(busy), 0);
        chk("ss_done", int'(done), 0);
        repeat (4) @(posedge clk);
        #1;
        chk("ss_still_idle", int'(busy), 0);

        for (int r = 0; r < 3; r++) begin
            n   = int'($urandom_range(1, 3));
            pre = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) mem[i] = 8'($urandom);
            run(n, pre, cnt);
        end

        // Stop during a gap of byte 1, then replay with an ignored mid-play start
        mem[0] = 8'h5A;
        mem[1] = 8'hC3;
        kick(2, 1'b0);
        cnt = 0;
        while (cnt < 5000 && exp_addr.size() != 0) begin
            @(posedge clk);
            cnt++;
        end
        while (cnt < 8000 && !(!tape_out && lo_len == LO_C + 4)) begin
            @(posedge clk);
            cnt++;
        end
        if (cnt >= 8000) fail("gap_timeout", cnt);
        #1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        chk("stop_tape", int'(tape_out), 0);
        chk("stop_busy", int'(busy), 0);
        chk("stop_done", int'(done), 0);
        chk("stop_mem_rd", int'(mem_rd), 0);
        flush();
        kick(2, 1'b0);
        cnt = 0;
        while (cnt < 5000 && exp_grp.size() > 12) begin
            @(posedge clk);
            cnt++;
        end
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
